// File: rtl/fp_pkg.sv
// IEEE-754 half/single format constants, rounding-mode and class enums
// shared by the result packer and its rounding unit.
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rm_e;

    typedef enum logic [1:0] {
        CL_NUM,
        CL_ZERO,
        CL_INF,
        CL_NAN
    } cls_e;

    localparam int H_E    = 5;
    localparam int H_M    = 10;
    localparam int H_BIAS = 15;
    localparam int H_EMIN = -14;

    localparam int S_E    = 8;
    localparam int S_M    = 23;
    localparam int S_BIAS = 127;
    localparam int S_EMIN = -126;

    localparam logic [31:0] NAN_H = 32'h0000_7E00;
    localparam logic [31:0] NAN_S = 32'h7FC0_0000;

endpackage

// File: rtl/fp_pack_round_if.sv
// Valid/ready transaction bundle between the arithmetic datapath (master)
// and the result packer (slave).
interface fp_pack_round_if #(
    parameter int SIG_W = 28,
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode_fp;
    logic [1:0]       in_rm;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [SIG_W-1:0] in_sig;
    logic             in_zero;
    logic             in_inf;
    logic             in_nan;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      fp_result;
    logic             out_overflow;
    logic             out_underflow;
    logic             out_inexact;

    modport master (
        output in_valid, in_mode_fp, in_rm, in_sign, in_exp, in_sig,
               in_zero, in_inf, in_nan, out_ready,
        input  in_ready, out_valid, fp_result, out_overflow, out_underflow,
               out_inexact
    );

    modport slave (
        input  in_valid, in_mode_fp, in_rm, in_sign, in_exp, in_sig,
               in_zero, in_inf, in_nan, out_ready,
        output in_ready, out_valid, fp_result, out_overflow, out_underflow,
               out_inexact
    );
endinterface

// File: rtl/fp_round_unit.sv
// Combinational mantissa rounder; half mantissas occupy the low 10 bits and
// carry out of bit 10, single mantissas carry out of bit 23.
module fp_round_unit
    import fp_pkg::*;
(
    input  logic        mode_fp_i,
    input  logic [22:0] mant_i,
    input  logic        guard_i,
    input  logic        sticky_i,
    input  logic        sign_i,
    input  rm_e         rm_i,
    output logic [22:0] mant_o,
    output logic        carry_o,
    output logic        inexact_o
);
    logic        inc;
    logic [23:0] sum;

    always_comb begin
        inexact_o = guard_i | sticky_i;
        unique case (rm_i)
            RM_RNE:  inc = guard_i & (sticky_i | mant_i[0]);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = inexact_o & ~sign_i;
            default: inc = inexact_o & sign_i;
        endcase
        sum = {1'b0, mant_i} + {23'b0, inc};
        if (mode_fp_i) begin
            carry_o = sum[23];
            mant_o  = sum[22:0];
        end else begin
            carry_o = sum[10];
            mant_o  = {13'b0, sum[9:0]};
        end
    end
endmodule

// File: rtl/fp_pack_round.sv
// Two-stage IEEE-754 half/single result packer: S1 classifies and prepares
// exponent/shift, S2 denormalises, rounds, saturates and packs.
module fp_pack_round
    import fp_pkg::*;
#(
    parameter int SIG_W = 28,
    parameter int EXP_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_pack_round_if.slave bus
);
    localparam int XW = EXP_W + 1;

    logic                 s1_valid_q, s1_mode_q, s1_sign_q, s1_sub_q;
    rm_e                  s1_rm_q;
    cls_e                 s1_cls_q, cls_d;
    logic [SIG_W-1:0]     s1_sig_q;
    logic signed [XW-1:0] s1_bexp_q, bexp_d;
    logic [4:0]           s1_shamt_q, shamt_d;
    logic                 sub_d, s1_adv;
    logic signed [XW-1:0] exp_x, emin_x, bias_x, diff_x;

    logic                 out_valid_q, ovf_q, unf_q, inx_q;
    logic [31:0]          result_q, res_d;
    logic                 ovf_d, unf_d, inx_d;

    logic [SIG_W-1:0]     shifted, lost_mask, low_mask;
    logic [22:0]          mant, mant_r, m_f;
    logic                 guard, sticky, carry, inexact_r, ovf, to_inf;
    logic [7:0]           e_f;
    logic signed [XW-1:0] exp_r, exp_max;

    assign s1_adv       = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = ~s1_valid_q | s1_adv;

    always_comb begin
        exp_x   = {bus.in_exp[EXP_W-1], bus.in_exp};
        emin_x  = bus.in_mode_fp ? XW'(S_EMIN) : XW'(H_EMIN);
        bias_x  = bus.in_mode_fp ? XW'(S_BIAS) : XW'(H_BIAS);
        diff_x  = emin_x - exp_x;
        sub_d   = exp_x < emin_x;
        bexp_d  = sub_d ? '0 : exp_x + bias_x;
        shamt_d = '0;
        // Shifts past M+2 put the hidden 1 entirely into sticky, so saturate there
        if (sub_d) begin
            if (bus.in_mode_fp)
                shamt_d = (diff_x > XW'(S_M + 2)) ? 5'(S_M + 2) : diff_x[4:0];
            else
                shamt_d = (diff_x > XW'(H_M + 2)) ? 5'(H_M + 2) : diff_x[4:0];
        end
        if (bus.in_nan)       cls_d = CL_NAN;
        else if (bus.in_inf)  cls_d = CL_INF;
        else if (bus.in_zero) cls_d = CL_ZERO;
        else                  cls_d = CL_NUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_rm_q    <= RM_RNE;
            s1_cls_q   <= CL_NUM;
            s1_sig_q   <= '0;
            s1_bexp_q  <= '0;
            s1_shamt_q <= '0;
        end else if (bus.in_ready) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mode_q  <= bus.in_mode_fp;
                s1_sign_q  <= bus.in_sign;
                s1_sub_q   <= sub_d;
                s1_rm_q    <= rm_e'(bus.in_rm);
                s1_cls_q   <= cls_d;
                s1_sig_q   <= bus.in_sig;
                s1_bexp_q  <= bexp_d;
                s1_shamt_q <= shamt_d;
            end
        end
    end

    always_comb begin
        shifted   = s1_sig_q >> s1_shamt_q;
        lost_mask = ~({SIG_W{1'b1}} << s1_shamt_q);
        if (s1_mode_q) begin
            mant     = shifted[SIG_W-2 -: 23];
            guard    = shifted[SIG_W-25];
            low_mask = ~({SIG_W{1'b1}} << (SIG_W - 25));
        end else begin
            mant     = {13'b0, shifted[SIG_W-2 -: 10]};
            guard    = shifted[SIG_W-12];
            low_mask = ~({SIG_W{1'b1}} << (SIG_W - 12));
        end
        sticky = (|(s1_sig_q & lost_mask)) | (|(shifted & low_mask));
    end

    fp_round_unit u_round (
        .mode_fp_i (s1_mode_q),
        .mant_i    (mant),
        .guard_i   (guard),
        .sticky_i  (sticky),
        .sign_i    (s1_sign_q),
        .rm_i      (s1_rm_q),
        .mant_o    (mant_r),
        .carry_o   (carry),
        .inexact_o (inexact_r)
    );

    always_comb begin
        // Subnormals carry into biased exponent 1, i.e. the smallest normal
        exp_r   = s1_bexp_q + {{(XW-1){1'b0}}, carry};
        exp_max = s1_mode_q ? XW'(255) : XW'(31);
        ovf     = exp_r >= exp_max;
        to_inf  = (s1_rm_q == RM_RNE) | ((s1_rm_q == RM_RUP) & ~s1_sign_q) |
                  ((s1_rm_q == RM_RDN) & s1_sign_q);
        if (ovf) begin
            e_f = s1_mode_q ? (to_inf ? 8'hFF : 8'hFE) : (to_inf ? 8'h1F : 8'h1E);
            m_f = to_inf ? '0 : '1;
        end else begin
            e_f = exp_r[7:0];
            m_f = mant_r;
        end
        res_d = s1_mode_q ? {s1_sign_q, e_f, m_f}
                          : {16'b0, s1_sign_q, e_f[4:0], m_f[9:0]};
        ovf_d = ovf;
        inx_d = inexact_r | ovf;
        unf_d = s1_sub_q & inexact_r;
        unique case (s1_cls_q)
            CL_NAN: begin
                res_d = s1_mode_q ? NAN_S : NAN_H;
                {ovf_d, unf_d, inx_d} = '0;
            end
            CL_INF: begin
                res_d = s1_mode_q ? {s1_sign_q, 8'hFF, 23'b0} : {16'b0, s1_sign_q, 5'h1F, 10'b0};
                {ovf_d, unf_d, inx_d} = '0;
            end
            CL_ZERO: begin
                res_d = s1_mode_q ? {s1_sign_q, 31'b0} : {16'b0, s1_sign_q, 15'b0};
                {ovf_d, unf_d, inx_d} = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= res_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                inx_q    <= inx_d;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.fp_result     = result_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_inexact   = inx_q;
endmodule

// File: tb/tb_fp_pack_round.sv
// Randomised scoreboard bench for fp_pack_round: an integer-quantisation
// reference model predicts every accepted transaction's packed word and flags.
module tb_fp_pack_round;
    localparam int SIG_W = 28;
    localparam int EXP_W = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_pack_round_if #(.SIG_W(SIG_W), .EXP_W(EXP_W)) bus ();

    fp_pack_round #(.SIG_W(SIG_W), .EXP_W(EXP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          rdy_mode = 2;
    bit          tog = 1'b0;
    logic [34:0] sb[$];
    bit          hold_pend = 1'b0;
    logic [34:0] hold_val;

    task automatic chk(input string name, input logic [34:0] got, input logic [34:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    // Quantise sig*2^(e-(SIG_W-1)) onto the grid 2^q of the target format.
    function automatic logic [34:0] model(input bit mode, input bit [1:0] rm, input bit sign,
                                          input int e, input longint sig,
                                          input bit z, input bit inf, input bit nan);
        int M, E, bias, emin, q, k, be;
        longint n, r, half, frac;
        bit inx, up, tiny, ovf, to_inf;
        logic [31:0] res;
        M    = mode ? 23 : 10;
        E    = mode ? 8 : 5;
        bias = mode ? 127 : 15;
        emin = mode ? -126 : -14;
        if (nan) return {3'b000, (mode ? 32'h7FC00000 : 32'h00007E00)};
        if (inf) return mode ? {3'b000, sign, 8'hFF, 23'h0} : {3'b000, 16'h0, sign, 5'h1F, 10'h0};
        if (z)   return mode ? {3'b000, sign, 31'h0} : {3'b000, 16'h0, sign, 15'h0};
        tiny = e < emin;
        q = (tiny ? emin : e) - M;
        k = (SIG_W - 1) + q - e;
        if (k > 40) begin
            n = 0; r = sig; half = longint'(1) << 40;
        end else begin
            n = sig >> k; r = sig - (n << k); half = longint'(1) << (k - 1);
        end
        inx = r != 0;
        case (rm)
            2'd0:    up = (r > half) || ((r == half) && n[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = inx && !sign;
            default: up = inx && sign;
        endcase
        n = n + longint'(up);
        if (n >= (longint'(1) << (M + 1))) begin n = n >> 1; q++; end
        if (n >= (longint'(1) << M)) begin
            be = q + M + bias; frac = n - (longint'(1) << M);
        end else begin
            be = 0; frac = n;
        end
        ovf = be >= (1 << E) - 1;
        to_inf = (rm == 2'd0) || (rm == 2'd2 && !sign) || (rm == 2'd3 && sign);
        if (ovf) begin
            be   = to_inf ? (1 << E) - 1 : (1 << E) - 2;
            frac = to_inf ? 0 : (longint'(1) << M) - 1;
        end
        res = mode ? {sign, be[7:0], frac[22:0]} : {16'h0, sign, be[4:0], frac[9:0]};
        return {ovf, tiny && inx, inx || ovf, res};
    endfunction

    function automatic logic [34:0] dut_word();
        return {bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.fp_result};
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'($urandom_range(0, 1));
            1:       begin bus.out_ready = tog; tog = ~tog; end
            default: bus.out_ready = 1'b1;
        endcase
    end

    // Single compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 35'(bus.out_valid), 35'd1);
                chk("hold_data", dut_word(), hold_val);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_output got %h required none", dut_word());
                end else begin
                    chk("result", dut_word(), sb.pop_front());
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_val  = dut_word();
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_mode_fp, bus.in_rm, bus.in_sign,
                                   int'(signed'(bus.in_exp)), longint'(bus.in_sig),
                                   bus.in_zero, bus.in_inf, bus.in_nan));
        end
    end

    task automatic send(input bit mode, input bit [1:0] rm, input bit sign, input int e,
                        input logic [27:0] sig, input bit z, input bit i, input bit n);
        bit acc;
        int unsigned cnt = 0;
        #1;
        bus.in_valid = 1'b1; bus.in_mode_fp = mode; bus.in_rm = rm; bus.in_sign = sign;
        bus.in_exp = 10'(e); bus.in_sig = sig;
        bus.in_zero = z; bus.in_inf = i; bus.in_nan = n;
        do begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); cnt++;
        end while (!acc && cnt < 200);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout got in_ready=0 required 1 within 200 cycles");
        end
    endtask

    task automatic pin_send(input int idx, input bit mode, input bit [1:0] rm, input bit sign,
                            input int e, input logic [27:0] sig, input bit z, input bit i,
                            input bit n, input logic [34:0] lit);
        chk($sformatf("pin%0d", idx), model(mode, rm, sign, e, longint'(sig), z, i, n), lit);
        send(mode, rm, sign, e, sig, z, i, n);
    endtask

    task automatic rand_send();
        bit mode, sign;
        bit [1:0] rm;
        int e, sp;
        logic [27:0] sig, m;
        mode = 1'($urandom_range(0, 1));
        rm   = 2'($urandom_range(0, 3));
        sign = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) e = int'($urandom_range(0, 1023)) - 512;
        else if (mode) e = int'($urandom_range(0, 300)) - 160;
        else e = int'($urandom_range(0, 60)) - 35;
        sig = 28'h8000000 | 28'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            m = (28'd1 << $urandom_range(0, 24)) - 28'd1;
            sig = (sig & ~m) | 28'h8000000;
        end
        sp = int'($urandom_range(0, 15));
        send(mode, rm, sign, e, sig, sp == 0 || sp == 3, sp == 1 || sp == 3, sp == 2);
    endtask

    task automatic idle();
        #1 bus.in_valid = 1'b0;
    endtask

    initial begin
        int unsigned w;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_mode_fp = 1'b0; bus.in_rm = 2'd0; bus.in_sign = 1'b0;
        bus.in_exp = '0; bus.in_sig = '0; bus.in_zero = 1'b0; bus.in_inf = 1'b0; bus.in_nan = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 35'(bus.out_valid), 35'd0);
        chk("reset_in_ready", 35'(bus.in_ready), 35'd1);
        chk("reset_word", dut_word(), 35'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk);

        pin_send(1,  1, 0, 0,   0, 28'h8000000, 0, 0, 0, {3'b000, 32'h3F800000});
        pin_send(2,  0, 0, 0,   0, 28'h8000000, 0, 0, 0, {3'b000, 32'h00003C00});
        pin_send(3,  0, 0, 0,   0, 28'h8010000, 0, 0, 0, {3'b001, 32'h00003C00});
        pin_send(4,  0, 0, 0,   0, 28'h8030000, 0, 0, 0, {3'b001, 32'h00003C02});
        pin_send(5,  0, 2, 0,   0, 28'h8010000, 0, 0, 0, {3'b001, 32'h00003C01});
        pin_send(6,  0, 0, 0,  16, 28'h8000000, 0, 0, 0, {3'b101, 32'h00007C00});
        pin_send(7,  0, 1, 0,  16, 28'h8000000, 0, 0, 0, {3'b101, 32'h00007BFF});
        pin_send(8,  0, 2, 1,  16, 28'h8000000, 0, 0, 0, {3'b101, 32'h0000FBFF});
        pin_send(9,  0, 0, 0, -24, 28'h8000000, 0, 0, 0, {3'b000, 32'h00000001});
        pin_send(10, 0, 0, 0, -25, 28'h8000000, 0, 0, 0, {3'b011, 32'h00000000});
        pin_send(11, 0, 2, 0, -25, 28'h8000000, 0, 0, 0, {3'b011, 32'h00000001});
        pin_send(12, 0, 0, 0,   0, 28'h8000000, 1, 1, 1, {3'b000, 32'h00007E00});
        pin_send(13, 1, 0, 0,   0, 28'h8000000, 1, 1, 1, {3'b000, 32'h7FC00000});
        pin_send(14, 1, 0, 1,   0, 28'h8000000, 0, 1, 0, {3'b000, 32'hFF800000});
        pin_send(15, 1, 0, 0, 127, 28'h8000000, 0, 0, 0, {3'b000, 32'h7F000000});

        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            rand_send();
            if (i == 3) begin
                #1 bus.in_valid = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("midreset_out_valid", 35'(bus.out_valid), 35'd0);
                chk("midreset_in_ready", 35'(bus.in_ready), 35'd1);
                @(posedge clk); #2 rst_n = 1'b1;
                @(posedge clk);
            end
        end

        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            rand_send();
            if ($urandom_range(0, 7) == 0) begin
                idle();
                @(posedge clk);
            end
        end
        idle();

        rdy_mode = 2;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk); w++;
        end
        @(negedge clk);
        chk("drain_empty", 35'(sb.size()), 35'd0);
        chk("drain_out_valid", 35'(bus.out_valid), 35'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
